// File: rtl/fetch_unit_if.sv
// Instruction-memory fetch bus between fetch_unit (master) and the memory (slave).
// Handshake: the master holds req high with a stable addr; a beat completes on any
// rising edge where req && ready, and rdata is only meaningful on that edge.
// ready is ignored while req is low.
interface fetch_unit_if;
  logic        req;
  logic [15:0] addr;
  logic        ready;
  logic [15:0] rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, fetches one word at a time over
// fetch_unit_if, holds it in the instruction register until downstream accepts it,
// then steps or branches the PC.
// Optional feature macro: FETCH_TIMEOUT_EN adds a fetch wait counter, a forced-NOP
// timeout and the sticky fetch_err_o port.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd1
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 15
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_unit_if.master        imem,
  output logic [15:0]         instr_o,
  output logic                instr_valid_o,
  output logic [13:0]         imm_field_o,
  input  logic                stall_i,
  input  logic                branch_taken_i,
  input  logic [15:0]         branch_offset_i,
  output logic [15:0]         pc_o,
`ifdef FETCH_TIMEOUT_EN
  output logic                fetch_err_o,
`endif
  output logic [1:0]          state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic        fetch_done;
  logic        timeout_hit;
  logic        advance;

  // A beat only counts while we are actually requesting.
  assign fetch_done = (state_q == S_FETCH) && imem.ready;
  // Downstream accepted the held instruction; branch inputs matter only here.
  assign advance    = (state_q == S_HOLD) && !stall_i;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       fetch_err_q, fetch_err_d;

  // Fires on the edge that would complete the TIMEOUT_CYC-th unanswered FETCH cycle.
  assign timeout_hit = (state_q == S_FETCH) && !imem.ready && (wait_cnt_q == TIMEOUT_LAST);

  // Wait counter is zero whenever we are not in FETCH, so each FETCH entry starts fresh.
  always_comb begin
    wait_cnt_d  = 8'd0;
    fetch_err_d = fetch_err_q | timeout_hit;
    if ((state_q == S_FETCH) && !imem.ready && !timeout_hit) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  // Timeout bookkeeping registers; fetch_err is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q  <= 8'd0;
      fetch_err_q <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign fetch_err_o = fetch_err_q;
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE is a one-cycle launch, FETCH waits for a beat, HOLD waits for !stall.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (fetch_done || timeout_hit) state_d = S_HOLD;
      S_HOLD:  if (!stall_i) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the registered state only.
  always_comb begin
    imem.req      = 1'b0;
    instr_valid_o = 1'b0;
    case (state_q)
      S_FETCH: imem.req      = 1'b1;
      S_HOLD:  instr_valid_o = 1'b1;
      default: begin
        imem.req      = 1'b0;
        instr_valid_o = 1'b0;
      end
    endcase
  end

  // Datapath next values: capture fetched word (or NOP on timeout), step/branch PC on advance.
  // PC arithmetic is plain 16-bit and wraps modulo 2^16.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    if (fetch_done) begin
      instr_d = imem.rdata;
    end else if (timeout_hit) begin
      instr_d = 16'h0000;
    end
    if (advance) begin
      if (branch_taken_i) begin
        pc_d = pc_q + PC_STEP + branch_offset_i;
      end else begin
        pc_d = pc_q + PC_STEP;
      end
    end
  end

  // PC and instruction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= 16'h0000;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign imem.addr   = pc_q;
  assign pc_o        = pc_q;
  assign instr_o     = instr_q;
  assign imm_field_o = instr_q[13:0];
  assign state_o     = state_q;

endmodule
